// File: rtl/fft_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_reader
// Purpose  : Streams frames of I/Q lane words out of a sample RAM toward the
//            FFT input stage. A run is started by a one-cycle start pulse and
//            consists of num_frames frames (0 = continuous until stop), each
//            WORDS_PER_FRAME words long, separated by gap_cycles idle cycles.
//            RAM read latency is one cycle; the output register adds one more,
//            so a read strobe at cycle t shows up on dout_*/valid at t+2.
// Ports    : clk, rstn (async, active-low)
//            start, stop          - run control pulses
//            num_frames           - frames per run, sampled on start
//            gap_cycles           - idle cycles between frames, sampled on start
//            ram_rd_en, ram_addr  - sample-RAM read port
//            ram_rdata_i/_q       - RAM read data (valid one cycle after read)
//            dout_i/_q, valid     - registered lane words to the FFT
//            busy, done           - run status
//            frames_sent          - frames completed in the current run
// Config   : FFT_FRAME_READER_ZERO_IDLE_EN - when defined, dout_i/dout_q are
//            driven to zero whenever valid is low; otherwise they hold the
//            last presented word.
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_reader #(
    parameter int DATA_WIDTH      = 9,
    parameter int NUM_IN_OUT      = 16,
    parameter int WORDS_PER_FRAME = 32,
    parameter int ADDR_W          = 10
) (
    input  logic                                           clk,
    input  logic                                           rstn,
    input  logic                                           start,
    input  logic                                           stop,
    input  logic        [7:0]                              num_frames,
    input  logic        [7:0]                              gap_cycles,
    output logic                                           ram_rd_en,
    output logic        [ADDR_W-1:0]                       ram_addr,
    input  logic signed [NUM_IN_OUT-1:0][DATA_WIDTH-1:0]   ram_rdata_i,
    input  logic signed [NUM_IN_OUT-1:0][DATA_WIDTH-1:0]   ram_rdata_q,
    output logic signed [NUM_IN_OUT-1:0][DATA_WIDTH-1:0]   dout_i,
    output logic signed [NUM_IN_OUT-1:0][DATA_WIDTH-1:0]   dout_q,
    output logic                                           valid,
    output logic                                           busy,
    output logic                                           done,
    output logic        [7:0]                              frames_sent
);

    localparam int                   c_WCNT_W    = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam logic [c_WCNT_W-1:0]  c_LAST_WORD = c_WCNT_W'(WORDS_PER_FRAME - 1);
    localparam logic [c_WCNT_W-1:0]  c_WCNT_ONE  = c_WCNT_W'(1);
    localparam logic [ADDR_W-1:0]    c_ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_GAP   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_WCNT_W-1:0]   r_word_cnt;
    logic [7:0]            r_gap_cnt;
    logic [7:0]            r_num_frames;
    logic [7:0]            r_gap;
    logic                  r_stop_pending;
    logic                  r_flush_cnt;
    logic                  r_rd_d1;
    logic                  w_last_frame;

    // The frame finishing now is the last of the run if the programmed count
    // is reached, or a stop has been seen (including one arriving this cycle).
    assign w_last_frame = r_stop_pending | stop |
                          ((r_num_frames != 8'd0) && ((frames_sent + 8'd1) == r_num_frames));

    // ------------------------------------------------------------------------
    // Control FSM: owns the read strobe, address, run status and counters.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= S_IDLE;
            r_word_cnt     <= '0;
            r_gap_cnt      <= '0;
            r_num_frames   <= '0;
            r_gap          <= '0;
            r_stop_pending <= 1'b0;
            r_flush_cnt    <= 1'b0;
            ram_rd_en      <= 1'b0;
            ram_addr       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            frames_sent    <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state        <= S_READ;
                        r_num_frames   <= num_frames;
                        r_gap          <= gap_cycles;
                        r_word_cnt     <= '0;
                        // A stop arriving together with start ends the run
                        // after its first frame.
                        r_stop_pending <= stop;
                        frames_sent    <= '0;
                        ram_addr       <= '0;
                        ram_rd_en      <= 1'b1;
                        busy           <= 1'b1;
                    end
                end

                S_READ: begin
                    if (stop) begin
                        r_stop_pending <= 1'b1;
                    end
                    ram_addr <= ram_addr + c_ADDR_ONE;
                    if (r_word_cnt == c_LAST_WORD) begin
                        r_word_cnt  <= '0;
                        frames_sent <= frames_sent + 8'd1;
                        if (w_last_frame) begin
                            r_state     <= S_FLUSH;
                            r_flush_cnt <= 1'b0;
                            ram_rd_en   <= 1'b0;
                        end else if (r_gap == 8'd0) begin
                            // Back-to-back frame: strobe stays high.
                            ram_rd_en <= 1'b1;
                        end else begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= '0;
                            ram_rd_en <= 1'b0;
                        end
                    end else begin
                        r_word_cnt <= r_word_cnt + c_WCNT_ONE;
                    end
                end

                S_GAP: begin
                    if (stop) begin
                        r_stop_pending <= 1'b1;
                        r_state        <= S_FLUSH;
                        r_flush_cnt    <= 1'b0;
                    end else if (r_gap_cnt == (r_gap - 8'd1)) begin
                        r_state   <= S_READ;
                        ram_rd_en <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 8'd1;
                    end
                end

                S_FLUSH: begin
                    // Two drain cycles; done is raised so that it lines up
                    // with the final word leaving the output register.
                    if (!r_flush_cnt) begin
                        r_flush_cnt <= 1'b1;
                        done        <= 1'b1;
                    end else begin
                        r_flush_cnt    <= 1'b0;
                        r_state        <= S_IDLE;
                        r_stop_pending <= 1'b0;
                        busy           <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Data path: r_rd_d1 marks the cycle RAM data is valid; the output
    // register captures it one cycle later together with valid.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_d1 <= 1'b0;
            valid   <= 1'b0;
            dout_i  <= '0;
            dout_q  <= '0;
        end else begin
            r_rd_d1 <= ram_rd_en;
            valid   <= r_rd_d1;
            if (r_rd_d1) begin
                dout_i <= ram_rdata_i;
                dout_q <= ram_rdata_q;
            end
`ifdef FFT_FRAME_READER_ZERO_IDLE_EN
            else begin
                dout_i <= '0;
                dout_q <= '0;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_frame_reader
// Purpose  : Self-checking bench for fft_frame_reader. A table of run
//            configurations is applied in a loop; a RAM model returns
//            address-derived lane data and a scoreboard queue pairs each read
//            strobe with the word expected two cycles later. Burst and gap
//            lengths, frame counts, final address and done pulses are checked
//            per run, followed by a mid-frame reset sequence.
// Config   : honours FFT_FRAME_READER_ZERO_IDLE_EN for idle-output checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_frame_reader;

    localparam int DW  = 9;
    localparam int NL  = 16;
    localparam int WPF = 32;
    localparam int AW  = 10;

    typedef logic [NL*DW-1:0] word_t;

    logic                        clk;
    logic                        rstn;
    logic                        start;
    logic                        stop;
    logic        [7:0]           num_frames;
    logic        [7:0]           gap_cycles;
    logic                        ram_rd_en;
    logic        [AW-1:0]        ram_addr;
    logic signed [NL-1:0][DW-1:0] ram_rdata_i;
    logic signed [NL-1:0][DW-1:0] ram_rdata_q;
    logic signed [NL-1:0][DW-1:0] dout_i;
    logic signed [NL-1:0][DW-1:0] dout_q;
    logic                        valid;
    logic                        busy;
    logic                        done;
    logic        [7:0]           frames_sent;

    fft_frame_reader #(
        .DATA_WIDTH      (DW),
        .NUM_IN_OUT      (NL),
        .WORDS_PER_FRAME (WPF),
        .ADDR_W          (AW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .stop        (stop),
        .num_frames  (num_frames),
        .gap_cycles  (gap_cycles),
        .ram_rd_en   (ram_rd_en),
        .ram_addr    (ram_addr),
        .ram_rdata_i (ram_rdata_i),
        .ram_rdata_q (ram_rdata_q),
        .dout_i      (dout_i),
        .dout_q      (dout_q),
        .valid       (valid),
        .busy        (busy),
        .done        (done),
        .frames_sent (frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always_ff @(posedge clk) cyc <= cyc + 1;

    // Lane data derived from the word address so lane order and word order
    // are both visible in the output.
    function automatic word_t mk_i(input logic [AW-1:0] a);
        word_t w;
        for (int l = 0; l < NL; l++) w[l*DW +: DW] = DW'(int'(a) + l);
        return w;
    endfunction

    function automatic word_t mk_q(input logic [AW-1:0] a);
        word_t w;
        for (int l = 0; l < NL; l++) w[l*DW +: DW] = DW'(int'(a) * 3 + 7 * l + 100);
        return w;
    endfunction

    // Sample RAM: one-cycle read latency.
    always_ff @(posedge clk) begin
        if (ram_rd_en) begin
            ram_rdata_i <= mk_i(ram_addr);
            ram_rdata_q <= mk_q(ram_addr);
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scoreboard / monitor (samples on the falling edge)
    // ------------------------------------------------------------------------
    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
    } rd_t;

    rd_t   sb[$];
    rd_t   pop_rec;
    word_t last_i = '0;
    word_t last_q = '0;
    int    cur_burst = 0;
    int    low_cnt   = 0;
    bit    have_burst = 1'b0;
    int    burst_q[$];
    int    gap_q[$];
    int    done_cnt = 0;
    int    done_on_valid = 0;

    always @(negedge clk) begin
        if (rstn) begin
            if (ram_rd_en) sb.push_back('{cyc, ram_addr});
            if (valid) begin
                if (cur_burst == 0 && have_burst) gap_q.push_back(low_cnt);
                cur_burst++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: valid at cycle %0d with no read outstanding", cyc);
                end else begin
                    pop_rec = sb.pop_front();
                    check("latency", 256'(cyc), 256'(pop_rec.cyc + 2));
                    check("dout_i", word_t'(dout_i), mk_i(pop_rec.addr));
                    check("dout_q", word_t'(dout_q), mk_q(pop_rec.addr));
                    last_i = mk_i(pop_rec.addr);
                    last_q = mk_q(pop_rec.addr);
                end
            end else begin
                if (cur_burst > 0) begin
                    burst_q.push_back(cur_burst);
                    have_burst = 1'b1;
                    cur_burst  = 0;
                    low_cnt    = 0;
                end
                low_cnt++;
`ifdef FFT_FRAME_READER_ZERO_IDLE_EN
                check("idle_dout_i", word_t'(dout_i), '0);
                check("idle_dout_q", word_t'(dout_q), '0);
`else
                check("idle_dout_i", word_t'(dout_i), last_i);
                check("idle_dout_q", word_t'(dout_q), last_q);
`endif
            end
            if (done) begin
                done_cnt++;
                if (valid) done_on_valid++;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Run table
    // ------------------------------------------------------------------------
    typedef struct {
        int nf;
        int gap;
        int stop_at;      // cycle offset from start to pulse stop, -1 = never
        int restart_at;   // cycle offset to pulse a second start, -1 = never
        int exp_frames;
        int exp_addr;
        int exp_aligned;  // done expected on the last valid word
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v);
        bit finished;
        int nb;
        int blen;
        sb.delete();
        burst_q.delete();
        gap_q.delete();
        cur_burst     = 0;
        low_cnt       = 0;
        have_burst    = 1'b0;
        done_cnt      = 0;
        done_on_valid = 0;
        finished      = 1'b0;

        @(posedge clk); #1;
        num_frames = 8'(v.nf);
        gap_cycles = 8'(v.gap);
        start      = 1'b1;
        stop       = (v.stop_at == 0);
        for (int c = 1; c < 3000; c++) begin
            @(posedge clk); #1;
            start = (c == v.restart_at);
            stop  = (c == v.stop_at);
            if (c > 1 && !busy) begin
                finished = 1'b1;
                break;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        if (!finished) begin
            total++;
            bad++;
            $display("FAIL run_timeout: busy still %0b after 3000 cycles", busy);
        end
        repeat (4) @(posedge clk);
        #1;

        nb   = (v.gap == 0) ? 1 : v.exp_frames;
        blen = (v.gap == 0) ? v.exp_frames * WPF : WPF;
        check("frames_sent", 256'(frames_sent), 256'(v.exp_frames));
        check("ram_addr_end", 256'(ram_addr), 256'(v.exp_addr));
        check("done_count", 256'(done_cnt), 256'd1);
        check("done_on_last", 256'(done_on_valid), 256'(v.exp_aligned));
        check("busy_end", 256'(busy), 256'd0);
        check("sb_empty", 256'(sb.size()), 256'd0);
        check("burst_count", 256'(burst_q.size()), 256'(nb));
        foreach (burst_q[i]) check("burst_len", 256'(burst_q[i]), 256'(blen));
        check("gap_count", 256'(gap_q.size()), 256'(nb - 1));
        foreach (gap_q[i]) check("gap_len", 256'(gap_q[i]), 256'(v.gap));
    endtask

    int act;

    initial begin
        rstn       = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        num_frames = 8'd0;
        gap_cycles = 8'd0;

        //          nf gap stop rest frames addr aligned
        vecs[0] = '{1, 0, -1, -1, 1, 32, 1};
        vecs[1] = '{3, 5, -1, -1, 3, 96, 1};
        vecs[2] = '{2, 0, -1, -1, 2, 64, 1};
        vecs[3] = '{0, 0, 43, -1, 2, 64, 1};   // stop at word 10 of frame 2
        vecs[4] = '{0, 4, 34, -1, 1, 32, 0};   // stop during the first gap
        vecs[5] = '{0, 0,  0, -1, 1, 32, 1};   // start and stop together
        vecs[6] = '{1, 0, -1, 10, 1, 32, 1};   // second start while reading
        vecs[7] = '{2, 4, -1, -1, 2, 64, 1};   // idle output during gap

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 256'(valid), 256'd0);
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_done", 256'(done), 256'd0);
        check("rst_rd_en", 256'(ram_rd_en), 256'd0);
        check("rst_addr", 256'(ram_addr), 256'd0);
        check("rst_frames", 256'(frames_sent), 256'd0);
        check("rst_dout_i", word_t'(dout_i), '0);
        check("rst_dout_q", word_t'(dout_q), '0);
        rstn = 1'b1;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset in the middle of a frame (word 15 being read).
        @(posedge clk); #1;
        num_frames = 8'd1;
        gap_cycles = 8'd0;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("pre_rst_addr", 256'(ram_addr), 256'd15);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", 256'(valid), 256'd0);
        check("mid_rst_busy", 256'(busy), 256'd0);
        check("mid_rst_rd_en", 256'(ram_rd_en), 256'd0);
        check("mid_rst_addr", 256'(ram_addr), 256'd0);
        check("mid_rst_frames", 256'(frames_sent), 256'd0);
        sb.delete();
        last_i = '0;
        last_q = '0;
        @(posedge clk); #1;
        rstn = 1'b1;
        act  = 0;
        repeat (20) begin
            @(negedge clk);
            if (ram_rd_en || valid || busy || done) act++;
        end
        check("post_rst_activity", 256'(act), 256'd0);
        check("post_rst_sb", 256'(sb.size()), 256'd0);

        // Normal operation resumes after reset.
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_frame_reader.md
FFT_FRAME_READER -- requirements
Module: fft_frame_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 9, bit width of each signed I/Q sample.
REQ-002 Parameter NUM_IN_OUT, default 16, number of parallel lanes per word.
REQ-003 Parameter WORDS_PER_FRAME, default 32, words per frame (32 x 16 = 512 samples).
REQ-004 Parameter ADDR_W, default 10, width of the RAM word address.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rstn  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse; begins a run.
REQ-008 stop  in  1  one-cycle pulse; ends the run after the current frame completes.
REQ-009 num_frames  in  8  frames per run, sampled on start; 0 = continuous until stop.
REQ-010 gap_cycles  in  8  idle cycles between frames, sampled on start.
REQ-011 ram_rd_en  out  1  sample-RAM read strobe.
REQ-012 ram_addr  out  ADDR_W  RAM word address.
REQ-013 ram_rdata_i / ram_rdata_q  in  NUM_IN_OUT x DATA_WIDTH signed  RAM read data, valid 1 cycle after ram_rd_en.
REQ-014 dout_i / dout_q  out  NUM_IN_OUT x DATA_WIDTH signed  registered lane words toward mod0_0 din_i/din_q.
REQ-015 valid  out  1  high exactly while dout_* carries a frame word; drives mod0_0 valid.
REQ-016 busy  out  1  high from the cycle after an accepted start until done.
REQ-017 done  out  1  one-cycle pulse when the last valid word of a run has been presented.
REQ-018 frames_sent  out  8  frames completed in the current run; wraps 255->0.

Function
REQ-019 FSM states IDLE, READ, GAP, FLUSH; reset state IDLE.
REQ-020 IDLE->READ on start: latch num_frames and gap_cycles, clear frames_sent, clear word counter; ram_addr restarts at 0.
REQ-021 READ asserts ram_rd_en for WORDS_PER_FRAME consecutive cycles; ram_addr increments by 1 per read, wrapping at 2^ADDR_W.
REQ-022 Read pipeline latency 2: ram_rd_en at cycle t -> valid and dout_* at t+2.
REQ-023 Frames are atomic: valid is high exactly WORDS_PER_FRAME consecutive cycles per frame, never split.
REQ-024 End of READ: frames_sent increments; if last frame (count reached, or stop pending) -> FLUSH; else if gap_cycles = 0 -> READ; else -> GAP.
REQ-025 gap_cycles = 0: back-to-back frames, valid stays high for N x WORDS_PER_FRAME cycles.
REQ-026 GAP holds ram_rd_en low for exactly gap_cycles cycles, then -> READ.
REQ-027 FLUSH waits 2 cycles for the pipeline to drain, pulses done on the cycle the last valid word is presented, then -> IDLE.
REQ-028 start while busy is ignored.
REQ-029 stop in IDLE is ignored.
REQ-030 stop in READ or GAP sets stop_pending, which is cleared on return to IDLE.
REQ-031 stop during GAP ends the run without another frame: -> FLUSH immediately.
REQ-032 start and stop in the same IDLE cycle: start is accepted, then the run stops after its first frame.
REQ-033 ram_addr continues from its last value across frames within a run.

Reset
REQ-034 rstn low asynchronously forces: state IDLE; ram_rd_en, valid, busy, done = 0; ram_addr, frames_sent, counters, stop_pending = 0; dout_i/dout_q = 0.
REQ-035 Reset mid-frame truncates the frame.
REQ-036 After reset is released, no output activity occurs until a new start.

Configuration
REQ-037 Macro FFT_FRAME_READER_ZERO_IDLE_EN.
REQ-038 When defined, dout_i/dout_q are forced to 0 on every cycle valid is low.
REQ-039 When undefined, dout_i/dout_q hold the last presented word while valid is low.
REQ-040 valid timing is identical in both builds.

Verification
REQ-041 Reset, start with num_frames=1, gap=0, RAM word k = k in all lanes -> valid high 32 cycles starting 2 cycles after the first ram_rd_en; dout lanes 0..31 in order; done pulses once; frames_sent=1.
REQ-042 num_frames=3, gap_cycles=5 -> three 32-cycle valid bursts separated by exactly 5 low cycles; ram_addr 0..95; frames_sent=3.
REQ-043 num_frames=0, gap=0, stop asserted at word 10 of frame 2 -> frame 2 completes (32 cycles), no frame 3, done 1 pulse, frames_sent=2.
REQ-044 start pulsed again during READ -> ignored; burst count and ram_addr unchanged.
REQ-045 rstn asserted at word 15 -> valid, busy, ram_rd_en, ram_addr, frames_sent = 0 immediately; no activity until the next start.
REQ-046 Both builds with gap=4: with FFT_FRAME_READER_ZERO_IDLE_EN, dout = 0 during the gap; without it, dout = word 31 during the gap.
